// File: rtl/pipe_fetch_queue.sv
// Instruction fetch queue between fetch and decode: DEPTH-entry FIFO of {inst, pc4} pairs
// with redirect flush. Define FETCHQ_BYPASS_EN to let an empty queue pass fetch straight to decode.
module pipe_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_inst,
   input  logic [31:0]   in_pc4,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_inst,
   output logic [31:0]   out_pc4,
   input  logic          flush,
   output logic [CW-1:0] count
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] rp;
   logic [AW-1:0] wp;
   logic [CW-1:0] cnt;

   logic empty;
   logic full;
   logic push;
   logic mem_rd;
   logic mem_wr;
   logic byp;
   logic byp_take;

   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_CNT);

`ifdef FETCHQ_BYPASS_EN
   // Empty queue: present the fetch word directly; consumed here means it is never stored.
   assign byp      = empty & in_valid & ~flush;
   assign byp_take = byp & out_ready;
`else
   assign byp      = 1'b0;
   assign byp_take = 1'b0;
`endif

   assign in_ready  = ~full & ~flush;
   assign out_valid = (~empty & ~flush) | byp;
   assign out_inst  = byp ? in_inst : mem[rp][63:32];
   assign out_pc4   = byp ? in_pc4  : mem[rp][31:0];
   assign count     = cnt;

   assign push   = in_valid & in_ready;
   assign mem_wr = push & ~byp_take;
   assign mem_rd = ~empty & ~flush & out_ready;

   always_ff @(posedge clock) begin
      if (mem_wr) begin
         mem[wp] <= {in_inst, in_pc4};
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
      end else begin
         if (mem_wr) begin
            wp <= wp + 1'b1;
         end
         if (mem_rd) begin
            rp <= rp + 1'b1;
         end
         case ({mem_wr, mem_rd})
            2'b10:   cnt <= cnt + ONE_CNT;
            2'b01:   cnt <= cnt - ONE_CNT;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule
